multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS-subset datapath.
- Decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback steps.
- It is the producer side of the ALUOp interface. It drives the 3-bit ALUOp consumed by the ALU controller, plus all datapath mux selects and write enables.
- Handshakes with the unified instruction/data memory through mem_ready_i.

---
 rtl/multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle MIPS-subset datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath select, write enable and the 3-bit ALUOp.
//
// Memory handshake: a request (mem_read_o or mem_write_o) is held for as long
// as the FSM sits in FETCH, MEMRD or MEMWR. The transfer completes in the
// cycle in which mem_ready_i is sampled high at the rising clock edge. No
// request is ever withdrawn early, except on a wait timeout (bus_err_o).
//
// Optional feature: define MULTICYCLE_CTRL_BNE_EN to decode BNE (0x05).
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       bus_err_o
);

    // Counter must hold values 0..WAIT_MAX; keep at least one bit so a
    // disabled timeout still elaborates cleanly.
    localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_RST    = 4'hF
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;
    logic             timeout;
    logic             branch_taken;

`ifdef MULTICYCLE_CTRL_BNE_EN
    logic is_bne_q, is_bne_d;

    // BNE/BEQ choice, captured while the opcode is decoded.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) is_bne_q <= 1'b0;
        else        is_bne_q <= is_bne_d;
    end

    // Capture the branch sense in DECODE, hold it otherwise.
    always_comb begin
        is_bne_d = is_bne_q;
        if (state_q == S_DECODE) is_bne_d = (opcode_i == OP_BNE);
    end

    assign branch_taken = is_bne_q ? ~zero_i : zero_i;
`else
    assign branch_taken = zero_i;
`endif

    // State register and memory wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_RST;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Timeout detection: an outstanding memory request that has already
    // waited WAIT_MAX cycles and is still not acknowledged this cycle.
    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR)) && !mem_ready_i;
        timeout = (WAIT_MAX != 0) && waiting &&
                  (wait_cnt_q == CNT_W'(WAIT_MAX));
    end

    // Next-state and Moore output decode, with mem_ready_i-gated enables.
    always_comb begin
        state_d      = S_FETCH;
        wait_cnt_d   = '0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b011;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        bus_err_o    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                state_d     = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:           state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:           state_d = S_BRANCH;
`endif
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    default: begin
                        illegal_o    = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                if (opcode_i == OP_LW)      state_d = S_MEMRD;
                else if (opcode_i == OP_SW) state_d = S_MEMWR;
                else                        state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                state_d    = mem_ready_i ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
                state_d      = mem_ready_i ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b000;
                state_d     = S_RWB;
            end
            S_RWB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 3'b100;
                pc_src_o     = 2'b01;
                pc_write_o   = branch_taken;
                instr_done_o = 1'b1;
            end
            S_JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (opcode_i == OP_SLTI) ? 3'b010 : 3'b011;
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            default: begin
                // RST and unused encodings: everything quiet, restart at FETCH.
                alu_op_o = 3'b000;
                state_d  = S_FETCH;
            end
        endcase

        // Abort an unanswered request: drop side effects, restart the fetch.
        if (timeout) begin
            bus_err_o   = 1'b1;
            mem_write_o = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            state_d     = S_FETCH;
            wait_cnt_d  = '0;
        end else if (waiting && (WAIT_MAX != 0)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a reference model expands each instruction into
// the per-cycle sequence of expected control words; a driver plays the plan
// and queues expectations; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int WT = 15;
  localparam int VW = 23;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       done;
    logic       ill;
    logic       berr;
  } vec_t;

  typedef struct packed {
    logic rdy;
    vec_t exp;
  } rec_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] opcode_i = 6'h00;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic       instr_done_o, illegal_o, bus_err_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  logic [VW-1:0] exp_q[$];
  rec_t          plan_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  vec_t          act;

  multicycle_ctrl #(.WAIT_MAX(WT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .state_o(state_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  assign act = {state_o, pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
                ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, instr_done_o, illegal_o, bus_err_o};

  // ---------------- reference model ----------------
  function automatic vec_t base(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    v.aop = 3'b011;
    return v;
  endfunction

  function automatic void add(input logic rdy, input vec_t v);
    rec_t r;
    r.rdy = rdy;
    r.exp = v;
    plan_q.push_back(r);
  endfunction

  // Cycle in which mem_ready_i is irrelevant: drive it randomly.
  function automatic void add_any(input vec_t v);
    add(1'($urandom_range(0, 1)), v);
  endfunction

  // A memory access: 'stalls' not-ready cycles then ready; the request is
  // abandoned on the not-ready cycle that follows WT earlier waits.
  function automatic bit mem_phase(input int stalls, input vec_t wv,
                                   input vec_t dv, input vec_t av);
    for (int i = 0; i < stalls; i++) begin
      if (i == WT) begin
        add(1'b0, av);
        return 1'b0;
      end
      add(1'b0, wv);
    end
    add(1'b1, dv);
    return 1'b1;
  endfunction

  function automatic void build_instr(input logic [5:0] op, input logic z,
                                     input int fst, input int mst);
    vec_t w, d, a, v;
    plan_q.delete();
    w = base(4'd0); w.mr = 1'b1; w.asb = 2'b01;
    d = w; d.irw = 1'b1; d.pcw = 1'b1;
    a = w; a.berr = 1'b1;
    if (!mem_phase(fst, w, d, a)) return;
    v = base(4'd1); v.asb = 2'b11;
    if (op == 6'h00) begin
      add_any(v);
      v = base(4'd6); v.asa = 1'b1; v.asb = 2'b00; v.aop = 3'b000; add_any(v);
      v = base(4'd7); v.rw = 1'b1; v.rd = 1'b1; v.done = 1'b1; add_any(v);
    end else if (op == 6'h23 || op == 6'h2B) begin
      add_any(v);
      v = base(4'd2); v.asa = 1'b1; v.asb = 2'b10; add_any(v);
      if (op == 6'h23) begin
        w = base(4'd3); w.mr = 1'b1; w.iord = 1'b1;
        a = w; a.berr = 1'b1;
        if (!mem_phase(mst, w, w, a)) return;
        v = base(4'd4); v.rw = 1'b1; v.m2r = 1'b1; v.done = 1'b1; add_any(v);
      end else begin
        w = base(4'd5); w.mw = 1'b1; w.iord = 1'b1;
        d = w; d.done = 1'b1;
        a = w; a.mw = 1'b0; a.berr = 1'b1;
        void'(mem_phase(mst, w, d, a));
      end
    end else if (op == 6'h04 || (BNE_EN && op == 6'h05)) begin
      add_any(v);
      v = base(4'd8); v.asa = 1'b1; v.asb = 2'b00; v.aop = 3'b100;
      v.pcs = 2'b01; v.pcw = (op == 6'h05) ? ~z : z; v.done = 1'b1;
      add_any(v);
    end else if (op == 6'h02) begin
      add_any(v);
      v = base(4'd9); v.pcs = 2'b10; v.pcw = 1'b1; v.done = 1'b1; add_any(v);
    end else if (op == 6'h08 || op == 6'h0A) begin
      add_any(v);
      v = base(4'd10); v.asa = 1'b1; v.asb = 2'b10;
      v.aop = (op == 6'h0A) ? 3'b010 : 3'b011; add_any(v);
      v = base(4'd11); v.rw = 1'b1; v.done = 1'b1; add_any(v);
    end else begin
      v.ill = 1'b1; v.done = 1'b1; add_any(v);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic play(input logic [5:0] op, input logic z, input int limit);
    opcode_i = op;
    zero_i = z;
    for (int i = 0; i < plan_q.size() && i < limit; i++) begin
      mem_ready_i = plan_q[i].rdy;
      exp_q.push_back(plan_q[i].exp);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic z, input int fst,
                     input int mst);
    build_instr(op, z, fst, mst);
    play(op, z, 1000);
  endtask

  task automatic do_reset(input int n);
    vec_t r;
    r = '0;
    r.st = 4'hF;
    rst_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready_i = 1'($urandom_range(0, 1));
      exp_q.push_back(r);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    exp_q.push_back(r);
    @(posedge clk_i); #1;
  endtask

  function automatic int pick_stall();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(0, 3);
    if (r < 88) return WT;
    if (r < 94) return WT + 1;
    return 0;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL ctrl_word t=%0t state got %0d want %0d : got %h want %h",
                 $time, act.st, e.st, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] op_tab[9];

  initial begin
    logic [5:0] op;
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h3F};
    @(posedge clk_i); #1;
    do_reset(3);
    run(6'h00, 1'b0, 2, 0);        // fetch wait then R-type
    run(6'h00, 1'b1, 0, 0);
    run(6'h23, 1'b0, 0, 3);        // LW with stalled read
    run(6'h04, 1'b1, 0, 0);        // BEQ taken
    run(6'h04, 1'b0, 0, 0);        // BEQ not taken
    run(6'h3F, 1'b0, 0, 0);        // illegal
    run(6'h05, 1'b0, 0, 0);        // BNE or illegal depending on build
    run(6'h2B, 1'b0, 0, WT + 1);   // write timeout
    run(6'h2B, 1'b1, 0, WT);       // ready on the last allowed cycle
    run(6'h00, 1'b0, WT + 1, 0);   // fetch timeout
    run(6'h23, 1'b1, 0, WT + 1);   // read timeout
    run(6'h02, 1'b0, 0, 0);
    run(6'h08, 1'b0, 0, 0);
    run(6'h0A, 1'b1, 1, 0);
    build_instr(6'h23, 1'b0, 0, 5); // reset in the middle of a stalled LW
    play(6'h23, 1'b0, 5);
    do_reset(2);
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 9) op = 6'($urandom_range(0, 63));
      else        op = op_tab[k];
      run(op, 1'($urandom_range(0, 1)), pick_stall(), pick_stall());
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
